mem_port_arbiter: RTL and testbench

Two-port arbiter and sequencer for the single-ported ARC main memory. It shares the memory's one address/data port between the instruction-fetch unit and the load/store unit using a req/ack handshake. It drives the memory's `rd`/`wr` strobes for exactly one cycle per transaction and captures the memory's registered read data. It also blocks data-port writes into the system-reserved region below the user base address.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/arb_pick.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the ARC main-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_t;

    localparam int unsigned USER_BASE_DEFAULT = 2048;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, d_err,
               mem_addr, mem_wdata, mem_rd, mem_wr, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, d_err,
               mem_addr, mem_wdata, mem_rd, mem_wr, busy
    );
endinterface

// File: rtl/arb_pick.sv
// Winner selection between fetch and data ports.
// MEM_ARB_RR_EN: round-robin with a last_grant register; otherwise data wins.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_elig_if,
    input  logic  i_elig_d,
    input  logic  i_grant,
    output logic  o_valid_c,
    output port_t o_port_c
);

    assign o_valid_c = i_elig_if | i_elig_d;

`ifdef MEM_ARB_RR_EN
    port_t r_last_grant;

    // Starts at fetch so the first conflict goes to the data port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= PORT_IF;
        end else if (i_grant) begin
            r_last_grant <= o_port_c;
        end
    end

    always_comb begin
        o_port_c = PORT_IF;
        if (i_elig_if && i_elig_d) begin
            o_port_c = (r_last_grant == PORT_IF) ? PORT_D : PORT_IF;
        end else if (i_elig_d) begin
            o_port_c = PORT_D;
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{clk, rst, i_grant};
    assign o_port_c = i_elig_d ? PORT_D : PORT_IF;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported ARC main memory between fetch and load/store units.
// Arbitration mode selected by MEM_ARB_RR_EN (see arb_pick).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned USER_BASE = USER_BASE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    port_t             r_port;
    port_t             w_pick_port;
    logic              w_pick_valid;
    logic              w_elig_if;
    logic              w_elig_d;
    logic              w_sel_we;
    logic              w_sel_prot;
    logic [ADDR_W-1:0] w_sel_addr;

    logic              r_we;
    logic              r_prot;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_mem_rd;
    logic              r_mem_wr;
    logic              r_if_ack;
    logic              r_d_ack;
    logic              r_d_err;

    logic              w_load;
    logic              w_cap_if;
    logic              w_cap_d;
    logic              w_mem_rd_nxt;
    logic              w_mem_wr_nxt;
    logic              w_if_ack_nxt;
    logic              w_d_ack_nxt;
    logic              w_d_err_nxt;

    // A port is not eligible during its own ack cycle.
    assign w_elig_if = bus.if_req & ~r_if_ack;
    assign w_elig_d  = bus.d_req  & ~r_d_ack;

    arb_pick u_arb_pick (
        .clk       (clk),
        .rst       (rst),
        .i_elig_if (w_elig_if),
        .i_elig_d  (w_elig_d),
        .i_grant   (w_load),
        .o_valid_c (w_pick_valid),
        .o_port_c  (w_pick_port)
    );

    assign w_sel_we   = (w_pick_port == PORT_D) & bus.d_we;
    assign w_sel_addr = (w_pick_port == PORT_D) ? bus.d_addr : bus.if_addr;
    assign w_sel_prot = w_sel_we & (bus.d_addr < ADDR_W'(USER_BASE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_pick_valid) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered strobes, acks and capture enables.
    always_comb begin
        w_load       = 1'b0;
        w_cap_if     = 1'b0;
        w_cap_d      = 1'b0;
        w_mem_rd_nxt = 1'b0;
        w_mem_wr_nxt = 1'b0;
        w_if_ack_nxt = 1'b0;
        w_d_ack_nxt  = 1'b0;
        w_d_err_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_load       = 1'b1;
                    w_mem_rd_nxt = ~w_sel_we;
                    w_mem_wr_nxt = w_sel_we & ~w_sel_prot;
                end
            end
            ST_RESP: begin
                if (r_port == PORT_IF) begin
                    w_if_ack_nxt = 1'b1;
                    w_cap_if     = 1'b1;
                end else begin
                    w_d_ack_nxt  = 1'b1;
                    w_d_err_nxt  = r_prot;
                    w_cap_d      = ~r_we;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_if_ack    <= 1'b0;
            r_d_ack     <= 1'b0;
            r_d_err     <= 1'b0;
            r_we        <= 1'b0;
            r_prot      <= 1'b0;
            r_port      <= PORT_IF;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_mem_rd <= w_mem_rd_nxt;
            r_mem_wr <= w_mem_wr_nxt;
            r_if_ack <= w_if_ack_nxt;
            r_d_ack  <= w_d_ack_nxt;
            r_d_err  <= w_d_err_nxt;
            if (w_load) begin
                r_mem_addr <= w_sel_addr;
                r_we       <= w_sel_we;
                r_prot     <= w_sel_prot;
                r_port     <= w_pick_port;
                if (w_pick_port == PORT_D) begin
                    r_mem_wdata <= bus.d_wdata;
                end
            end
            if (w_cap_if) r_if_rdata <= bus.mem_rdata;
            if (w_cap_d)  r_d_rdata  <= bus.mem_rdata;
        end
    end

    assign bus.if_ack    = r_if_ack;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_ack     = r_d_ack;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_err     = r_d_err;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_rd    = r_mem_rd;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small registered memory model
// and per-port scoreboards holding expected ack cycle, data and error flag.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .USER_BASE (2048)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        bit          chk_data;
        bit          err;
    } exp_t;

    exp_t q_if[$];
    exp_t q_d[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int n_wr     = 0;

    // Registered-read memory; program image reloaded on reset.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (rst) begin
            mem[0]        <= 32'h81C0_2800;
            mem[512]      <= 32'hC200_2844;
            mem[513]      <= 32'h8280_4002;
            mem[522]      <= 32'h0000_0000;
            mem[529]      <= 32'h0000_0001;
            bus.mem_rdata <= 32'h0;
        end else begin
            if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr[11:2]];
            if (bus.mem_wr) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample after the edge and score any acks.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.mem_wr === 1'b1) n_wr++;
        if (bus.if_ack === 1'b1) begin
            if (q_if.size() == 0) begin
                chk("if_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = q_if.pop_front();
                chk("if_ack_cycle", 32'(cyc), 32'(e.cyc));
                chk("if_rdata", bus.if_rdata, e.data);
            end
        end
        if (bus.d_ack === 1'b1) begin
            if (q_d.size() == 0) begin
                chk("d_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = q_d.pop_front();
                chk("d_ack_cycle", 32'(cyc), 32'(e.cyc));
                chk("d_err", 32'(bus.d_err), 32'(e.err));
                if (e.chk_data) chk("d_rdata", bus.d_rdata, e.data);
            end
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 12; i++) begin
            if (q_if.size() == 0 && q_d.size() == 0) break;
            tick();
        end
        chk("sb_if_drained", 32'(q_if.size()), 32'd0);
        chk("sb_d_drained", 32'(q_d.size()), 32'd0);
    endtask

    // Single transaction: strobe checks at ISSUE/RESP, ack scored by tick().
    task automatic do_req(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data,
                          input bit exp_err);
        exp_t e;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        e.cyc = cyc + 3; e.data = exp_data; e.chk_data = !we; e.err = exp_err;
        if (is_d) q_d.push_back(e); else q_if.push_back(e);
        tick();
        chk("issue_rd", 32'(bus.mem_rd), 32'(!we));
        chk("issue_wr", 32'(bus.mem_wr), 32'(we && !exp_err));
        chk("issue_addr", bus.mem_addr, addr);
        tick();
        chk("resp_strobes", 32'({bus.mem_rd, bus.mem_wr}), 32'd0);
        tick();
        if (is_d) bus.d_req = 1'b0; else bus.if_req = 1'b0;
        tick();
        wait_done();
    endtask

    initial begin
        int n;
        int wr0;
        exp_t e;
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        tick();
        tick();
        chk("rst_if_ack", 32'(bus.if_ack), 32'd0);
        chk("rst_d_ack", 32'(bus.d_ack), 32'd0);
        chk("rst_d_err", 32'(bus.d_err), 32'd0);
        chk("rst_strobes", 32'({bus.mem_rd, bus.mem_wr}), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_d_rdata", bus.d_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // Program fetch.
        chk("idle_busy", 32'(bus.busy), 32'd0);
        do_req(1'b0, 1'b0, 32'd2048, 32'd0, 32'hC200_2844, 1'b0);

        // Data write then read back; fetch data untouched.
        do_req(1'b1, 1'b1, 32'd2088, 32'h0000_0005, 32'd0, 1'b0);
        do_req(1'b1, 1'b0, 32'd2088, 32'd0, 32'h0000_0005, 1'b0);
        chk("if_rdata_isolated", bus.if_rdata, 32'hC200_2844);

        // Protected write refused; read below base allowed.
        wr0 = n_wr;
        do_req(1'b1, 1'b1, 32'd4, 32'hFFFF_FFFF, 32'd0, 1'b1);
        chk("prot_no_wr", 32'(n_wr - wr0), 32'd0);
        chk("d_rdata_held", bus.d_rdata, 32'h0000_0005);
        do_req(1'b1, 1'b0, 32'd0, 32'd0, 32'h81C0_2800, 1'b0);
        chk("d_rdata_isolated_if", bus.if_rdata, 32'hC200_2844);

        // Reset during ISSUE aborts the fetch.
        bus.if_req = 1'b1; bus.if_addr = 32'd2052;
        tick();
        chk("abort_issue_rd", 32'(bus.mem_rd), 32'd1);
        rst = 1'b1; bus.if_req = 1'b0;
        tick();
        rst = 1'b0;
        chk("abort_strobes", 32'({bus.mem_rd, bus.mem_wr}), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_if_rdata", bus.if_rdata, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_ack", 32'({bus.if_ack, bus.d_ack}), 32'd0);
        end
        do_req(1'b0, 1'b0, 32'd2052, 32'd0, 32'h8280_4002, 1'b0);

        // Fetch held through its ack: re-accepted at N+4, acked at N+7.
        bus.if_req = 1'b1; bus.if_addr = 32'd2048;
        n = cyc;
        e.data = 32'hC200_2844; e.chk_data = 1'b1; e.err = 1'b0;
        e.cyc = n + 3; q_if.push_back(e);
        e.cyc = n + 7; q_if.push_back(e);
        tick();
        chk("hold_rd_n1", 32'(bus.mem_rd), 32'd1);
        tick();
        tick();
        tick();
        chk("hold_rd_n4", 32'(bus.mem_rd), 32'd0);
        chk("hold_busy_n4", 32'(bus.busy), 32'd0);
        tick();
        chk("hold_rd_n5", 32'(bus.mem_rd), 32'd1);
        tick();
        tick();
        bus.if_req = 1'b0;
        tick();
        wait_done();

        // Conflict right after reset: data first, fetch follows.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        bus.if_req = 1'b1; bus.if_addr = 32'd2052;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd2116;
        n = cyc;
        e.cyc = n + 3; e.data = 32'h0000_0001; e.chk_data = 1'b1; e.err = 1'b0;
        q_d.push_back(e);
        e.cyc = n + 6; e.data = 32'h8280_4002;
        q_if.push_back(e);
        tick();
        chk("conf_first_addr", bus.mem_addr, 32'd2116);
        tick();
        tick();
        bus.d_req = 1'b0;
        tick();
        chk("conf_second_addr", bus.mem_addr, 32'd2052);
        chk("conf_second_rd", 32'(bus.mem_rd), 32'd1);
        tick();
        tick();
        bus.if_req = 1'b0;
        tick();
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
